// File: rtl/alu_core.sv
// alu_core: 32-bit ALU (add/sub/slt/logic) with registered result and flags
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       command,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow
);
  logic             inv;
  logic             arith;
  logic             cout;
  logic             ovf;
  logic             lt;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] res_n;
  always_comb begin
    inv   = command == 3'd1 || command == 3'd3;
    arith = command[2:1] == 2'b00;
    bx    = inv ? ~b : b;
    {cout, sum} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, inv};
    ovf   = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    lt    = sum[WIDTH-1] ^ ovf;
    res_n = arith            ? sum :
            command == 3'd2  ? a ^ b :
            command == 3'd3  ? {{(WIDTH-1){1'b0}}, lt} :
            command == 3'd4  ? a & b :
            command == 3'd5  ? ~(a & b) :
            command == 3'd6  ? ~(a | b) :
                               a | b;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
    end else begin
      result   <= res_n;
      carryout <= arith & cout;
      overflow <= arith & ovf;
      zero     <= res_n == '0;
    end
  end
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: table vectors, hand sequences and random checks against a behavioural model
module tb_alu_core;
  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  command = '0;
  logic [31:0] result;
  logic        carryout;
  logic        zero;
  logic        overflow;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        tbl[25];
  alu_core #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .command(command),
    .result(result), .carryout(carryout), .zero(zero), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic void model(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic co, output logic v, output logic z);
    longint s;
    co = 1'b0;
    v  = 1'b0;
    case (c)
      3'd0: begin
        r  = x + y;
        co = (64'(x) + 64'(y)) > 64'hFFFF_FFFF;
        s  = longint'($signed(x)) + longint'($signed(y));
        v  = s != longint'($signed(r));
      end
      3'd1: begin
        r  = x - y;
        co = x >= y;
        s  = longint'($signed(x)) - longint'($signed(y));
        v  = s != longint'($signed(r));
      end
      3'd2: r = x ^ y;
      3'd3: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd4: r = x & y;
      3'd5: r = ~(x & y);
      3'd6: r = ~(x | y);
      default: r = x | y;
    endcase
    z = r == 32'd0;
  endfunction
  task automatic check(input string nm, input logic [31:0] er, input logic ec, input logic ev, input logic ez);
    n_vec++;
    if (result !== er || carryout !== ec || overflow !== ev || zero !== ez) begin
      n_err++;
      $display("FAIL %s: got res=%h cout=%b ovf=%b zero=%b, want res=%h cout=%b ovf=%b zero=%b",
               nm, result, carryout, overflow, zero, er, ec, ev, ez);
    end
  endtask
  task automatic apply(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    command = c;
    a = x;
    b = y;
    @(posedge clk);
    #1;
  endtask
  task automatic apply_model(input string nm, input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    logic co, v, z;
    model(c, x, y, r, co, v, z);
    apply(c, x, y);
    check(nm, r, co, v, z);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    tbl[0]  = '{3'd0, 32'hD000_0000, 32'h9000_0000, 32'h6000_0000, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{3'd0, 32'h5000_0000, 32'hF000_0000, 32'h4000_0000, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{3'd0, 32'h7000_0000, 32'h6000_0000, 32'hD000_0000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{3'd0, 32'h8000_0000, 32'h6000_0000, 32'hE000_0000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{3'd0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{3'd1, 32'hD000_0000, 32'h7000_0000, 32'h6000_0000, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{3'd1, 32'h5000_0000, 32'h1000_0000, 32'h4000_0000, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{3'd1, 32'h7000_0000, 32'hA000_0000, 32'hD000_0000, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{3'd1, 32'h8000_0000, 32'hA000_0000, 32'hE000_0000, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{3'd1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{3'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{3'd3, 32'h0000_0005, 32'h0000_0006, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{3'd3, 32'h0000_0001, 32'h0000_0010, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{3'd3, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{3'd3, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{3'd3, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{3'd5, 32'h00FF_00FF, 32'h0000_FFFF, 32'hFFFF_FF00, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{3'd4, 32'h00FF_00FF, 32'h0000_FFFF, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{3'd2, 32'h00FF_00FF, 32'h0000_FFFF, 32'h00FF_FF00, 1'b0, 1'b0, 1'b0};
    tbl[22] = '{3'd6, 32'h00FF_00FF, 32'h0000_FFFF, 32'hFF00_0000, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{3'd7, 32'h00FF_00FF, 32'h0000_FFFF, 32'h00FF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[24] = '{3'd4, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0;
    a = 32'd5;
    b = 32'd3;
    command = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 32'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", 32'd8, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      apply(tbl[i].cmd, tbl[i].a, tbl[i].b);
      check($sformatf("tbl%0d_cmd%0d", i, tbl[i].cmd), tbl[i].res, tbl[i].cout, tbl[i].ovf, tbl[i].zero);
    end
    for (int i = 0; i < 8; i++) begin
      logic [2:0] seq [4];
      seq = '{3'd0, 3'd1, 3'd7, 3'd3};
      apply_model($sformatf("b2b%0d", i), seq[i % 4], pick(), pick());
    end
    @(negedge clk);
    rst_n = 1'b0;
    command = 3'd0;
    a = 32'hFFFF_FFFF;
    b = 32'h0000_0001;
    @(posedge clk);
    #1;
    check("mid_reset", 32'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    apply_model("after_mid_reset", 3'd1, 32'h8000_0000, 32'h0000_0001);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] x;
      x = pick();
      apply_model($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), x, ($urandom_range(0, 7) == 0) ? x : pick());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
